// File: rtl/level_calibrator_pkg.sv
// Shared definitions for the level calibrator: FSM encoding, percent scale and
// default widths, so the display and alarm stages agree on them.
package level_calibrator_pkg;

   localparam int RAW_W_DEFAULT = 12;
   localparam int PCT_W_DEFAULT = 7;
   localparam int PCT_MAX       = 100;

   // Calibration defaults: high point at full scale, low point at zero.
   localparam bit CAL_HIGH_RST_BIT = 1'b1;
   localparam bit CAL_LOW_RST_BIT  = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLAMP = 2'd1,
      DIV   = 2'd2,
      DONE  = 2'd3
   } calState_e;

endpackage

// File: rtl/level_calibrator_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, W steps after start.
// done_o is high during the final step; the quotient is settled the cycle after.
module seq_divider #(
   parameter int W     = 19,
   parameter int OUT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [W-1:0]     dividend_i,
   input  logic [W-1:0]     divisor_i,
   output logic [OUT_W-1:0] quotient_o,
   output logic             done_o
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, den_q, den_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          run_q, run_d;
   logic [W:0]    remShift;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         quo_q <= '0;
         den_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         den_q <= den_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   // Shift the next dividend bit into the remainder, subtract if it fits.
   always_comb begin
      rem_d    = rem_q;
      quo_d    = quo_q;
      den_d    = den_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      remShift = {rem_q, quo_q[W-1]};
      if (abort_i) begin
         run_d = 1'b0;
      end else if (start_i) begin
         rem_d = '0;
         quo_d = dividend_i;
         den_d = divisor_i;
         cnt_d = CW'(W);
         run_d = 1'b1;
      end else if (run_q) begin
         if (remShift >= {1'b0, den_q}) begin
            rem_d = W'(remShift - {1'b0, den_q});
            quo_d = {quo_q[W-2:0], 1'b1};
         end else begin
            rem_d = remShift[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b0};
         end
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            run_d = 1'b0;
         end
      end
   end

   assign done_o     = run_q && (cnt_q == CW'(1)) && !abort_i;
   assign quotient_o = quo_q[OUT_W-1:0];

endmodule

// File: rtl/level_calibrator.sv
// Stores full/empty calibration snapshots from debounced commands and converts
// each raw level sample into a 0..100 percent with a one-cycle valid strobe.
module level_calibrator
   import level_calibrator_pkg::*;
#(
   parameter int RAW_W = RAW_W_DEFAULT,
   parameter int PCT_W = PCT_W_DEFAULT
) (
   input  logic             clk_100MHz,
   input  logic             reset,
   input  logic             reset_cmd,
   input  logic             saveH_cmd,
   input  logic             saveL_cmd,
   input  logic [RAW_W-1:0] raw_level,
   input  logic             raw_valid,
   output logic [RAW_W-1:0] cal_high,
   output logic [RAW_W-1:0] cal_low,
   output logic             cal_ok,
   output logic [PCT_W-1:0] level_pct,
   output logic             pct_valid,
   output logic             busy
);

   localparam int NUM_W = RAW_W + 7;
   localparam logic [RAW_W-1:0] CAL_HIGH_RST = {RAW_W{CAL_HIGH_RST_BIT}};
   localparam logic [RAW_W-1:0] CAL_LOW_RST  = {RAW_W{CAL_LOW_RST_BIT}};

   calState_e        state_q, state_d;
   logic [RAW_W-1:0] sample_q, calHigh_q, calHigh_d, calLow_q, calLow_d;
   logic [PCT_W-1:0] pct_q, pct_d, result_q, result_d, divQuot;
   logic             pctValid_q, pctValid_d, useDiv_q, useDiv_d;
   logic             resetCmd_q, saveHCmd_q, saveLCmd_q;
   logic             resetEdge, saveHEdge, saveLEdge, calOk;
   logic             divStart, divAbort, divDone;
   logic [NUM_W-1:0] numerator, denominator;

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         sample_q   <= '0;
         calHigh_q  <= CAL_HIGH_RST;
         calLow_q   <= CAL_LOW_RST;
         pct_q      <= '0;
         pctValid_q <= 1'b0;
         result_q   <= '0;
         useDiv_q   <= 1'b0;
         resetCmd_q <= 1'b0;
         saveHCmd_q <= 1'b0;
         saveLCmd_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sample_q   <= raw_valid ? raw_level : sample_q;
         calHigh_q  <= calHigh_d;
         calLow_q   <= calLow_d;
         pct_q      <= pct_d;
         pctValid_q <= pctValid_d;
         result_q   <= result_d;
         useDiv_q   <= useDiv_d;
         resetCmd_q <= reset_cmd;
         saveHCmd_q <= saveH_cmd;
         saveLCmd_q <= saveL_cmd;
      end
   end

   // Commands are levels lasting many cycles; only the rising edge acts.
   assign resetEdge   = reset_cmd & ~resetCmd_q;
   assign saveHEdge   = saveH_cmd & ~saveHCmd_q;
   assign saveLEdge   = saveL_cmd & ~saveLCmd_q;
   assign calOk       = calHigh_q > calLow_q;
   assign numerator   = NUM_W'(sample_q - calLow_q) * NUM_W'(PCT_MAX);
   assign denominator = NUM_W'(calHigh_q - calLow_q);

   always_comb begin
      state_d    = state_q;
      calHigh_d  = calHigh_q;
      calLow_d   = calLow_q;
      pct_d      = pct_q;
      pctValid_d = 1'b0;
      result_d   = result_q;
      useDiv_d   = useDiv_q;
      divStart   = 1'b0;
      divAbort   = 1'b0;
      if (resetEdge) begin
         calHigh_d = CAL_HIGH_RST;
         calLow_d  = CAL_LOW_RST;
      end else if (saveHEdge) begin
         calHigh_d = sample_q;
      end else if (saveLEdge) begin
         calLow_d = sample_q;
      end
      if (resetEdge) begin
         state_d  = IDLE;
         divAbort = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (raw_valid) begin
                  if (calOk) begin
                     state_d = CLAMP;
                  end else begin
                     pct_d      = '0;
                     pctValid_d = 1'b1;
                  end
               end
            end
            CLAMP: begin
               state_d = DONE;
               if (sample_q <= calLow_q) begin
                  result_d = '0;
                  useDiv_d = 1'b0;
               end else if (sample_q >= calHigh_q) begin
                  result_d = PCT_W'(PCT_MAX);
                  useDiv_d = 1'b0;
               end else begin
                  useDiv_d = 1'b1;
                  divStart = 1'b1;
                  state_d  = DIV;
               end
            end
            DIV: begin
               if (divDone) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               pct_d      = useDiv_q ? divQuot : result_q;
               pctValid_d = 1'b1;
               state_d    = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   seq_divider #(
      .W     (NUM_W),
      .OUT_W (PCT_W)
   ) uDivider (
      .clk        (clk_100MHz),
      .rst        (reset),
      .start_i    (divStart),
      .abort_i    (divAbort),
      .dividend_i (numerator),
      .divisor_i  (denominator),
      .quotient_o (divQuot),
      .done_o     (divDone)
   );

   assign cal_high  = calHigh_q;
   assign cal_low   = calLow_q;
   assign cal_ok    = calOk;
   assign level_pct = pct_q;
   assign pct_valid = pctValid_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_level_calibrator.sv
// Directed bench for level_calibrator: hand-computed percents, latencies,
// calibration commands, command priority and both reset paths.
module tb_level_calibrator;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        reset_cmd = 1'b0, saveH_cmd = 1'b0, saveL_cmd = 1'b0;
   logic [11:0] raw_level = '0;
   logic        raw_valid = 1'b0;
   logic [11:0] cal_high, cal_low;
   logic        cal_ok, pct_valid, busy;
   logic [6:0]  level_pct;
   int          checkCount = 0;
   int          passCount  = 0;
   int          failCount  = 0;
   int          pulses;

   level_calibrator dut (
      .clk_100MHz (clk),
      .reset      (reset),
      .reset_cmd  (reset_cmd),
      .saveH_cmd  (saveH_cmd),
      .saveL_cmd  (saveL_cmd),
      .raw_level  (raw_level),
      .raw_valid  (raw_valid),
      .cal_high   (cal_high),
      .cal_low    (cal_low),
      .cal_ok     (cal_ok),
      .level_pct  (level_pct),
      .pct_valid  (pct_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // One-cycle raw sample; returns at the falling edge after it was taken.
   task automatic applyStimulus(input logic [11:0] value);
      @(negedge clk);
      raw_level = value;
      raw_valid = 1'b1;
      @(negedge clk);
      raw_valid = 1'b0;
   endtask

   // Waits for pct_valid; expLat of 0 skips the latency comparison.
   task automatic waitResult(input string tag, input int expLat, input int expPct);
      int lat = 1;
      while (!pct_valid && lat <= 40) begin
         @(negedge clk);
         lat++;
      end
      if (expLat > 0) checkOutput({tag, "_lat"}, lat, expLat);
      else checkOutput({tag, "_seen"}, 32'(lat <= 40), 32'd1);
      checkOutput({tag, "_pct"}, 32'(level_pct), expPct);
      @(negedge clk);
      checkOutput({tag, "_width"}, 32'(pct_valid), 32'd0);
   endtask

   task automatic pressCmd(input int which);
      @(negedge clk);
      case (which)
         0: reset_cmd = 1'b1;
         1: saveH_cmd = 1'b1;
         default: saveL_cmd = 1'b1;
      endcase
      @(negedge clk);
      reset_cmd = 1'b0;
      saveH_cmd = 1'b0;
      saveL_cmd = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      checkOutput("rst_calHigh", 32'(cal_high), 32'hFFF);
      checkOutput("rst_calLow", 32'(cal_low), 32'd0);
      checkOutput("rst_calOk", 32'(cal_ok), 32'd1);
      checkOutput("rst_pct", 32'(level_pct), 32'd0);
      checkOutput("rst_valid", 32'(pct_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;

      applyStimulus(12'h800);
      checkOutput("busy_clamp", 32'(busy), 32'd1);
      waitResult("half_default", 22, 50);
      checkOutput("idle_busy", 32'(busy), 32'd0);

      applyStimulus(12'd200);
      waitResult("low200_default", 22, 4);
      @(negedge clk);
      saveL_cmd = 1'b1;
      repeat (2000) @(negedge clk);
      checkOutput("saveL_value", 32'(cal_low), 32'd200);
      applyStimulus(12'd999);
      waitResult("held_saveL_conv", 22, 20);
      checkOutput("saveL_once", 32'(cal_low), 32'd200);
      saveL_cmd = 1'b0;

      applyStimulus(12'd1200);
      waitResult("high1200_conv", 22, 25);
      pressCmd(1);
      checkOutput("saveH_value", 32'(cal_high), 32'd1200);
      checkOutput("calOk_valid", 32'(cal_ok), 32'd1);

      applyStimulus(12'd700);
      waitResult("pct50", 22, 50);
      applyStimulus(12'd450);
      waitResult("pct25", 22, 25);
      applyStimulus(12'd150);
      waitResult("clamp_low", 3, 0);
      applyStimulus(12'd1300);
      waitResult("clamp_high", 3, 100);
      applyStimulus(12'd200);
      waitResult("clamp_eq_low", 3, 0);
      applyStimulus(12'd1200);
      waitResult("clamp_eq_high", 3, 100);

      // A save mid-division moves the point but the division keeps old operands.
      applyStimulus(12'd950);
      repeat (5) @(negedge clk);
      pressCmd(1);
      checkOutput("saveH_middiv", 32'(cal_high), 32'd950);
      waitResult("old_operands", 0, 75);
      applyStimulus(12'd1200);
      waitResult("clamp_new_high", 3, 100);
      pressCmd(1);

      applyStimulus(12'd300);
      waitResult("pct10", 22, 10);
      pressCmd(1);
      applyStimulus(12'd900);
      waitResult("clamp_300", 3, 100);
      pressCmd(2);
      checkOutput("calOk_invalid", 32'(cal_ok), 32'd0);
      applyStimulus(12'd500);
      waitResult("invalid_cal", 1, 0);

      pressCmd(0);
      checkOutput("resetCmd_high", 32'(cal_high), 32'hFFF);
      checkOutput("resetCmd_calOk", 32'(cal_ok), 32'd1);
      applyStimulus(12'd100);
      waitResult("pct2", 22, 2);
      pressCmd(2);
      applyStimulus(12'h400);
      repeat (10) @(negedge clk);
      reset_cmd = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_calLow", 32'(cal_low), 32'd0);
      checkOutput("abort_pctKept", 32'(level_pct), 32'd2);
      pulses = 0;
      repeat (30) begin
         if (pct_valid) pulses++;
         @(negedge clk);
      end
      checkOutput("abort_noValid", pulses, 0);
      reset_cmd = 1'b0;

      applyStimulus(12'd500);
      waitResult("pct12", 22, 12);
      pressCmd(1);
      applyStimulus(12'd250);
      waitResult("pct50_small", 22, 50);
      @(negedge clk);
      reset_cmd = 1'b1;
      saveH_cmd = 1'b1;
      saveL_cmd = 1'b1;
      @(negedge clk);
      checkOutput("prio_high", 32'(cal_high), 32'hFFF);
      checkOutput("prio_low", 32'(cal_low), 32'd0);
      reset_cmd = 1'b0;
      saveH_cmd = 1'b0;
      saveL_cmd = 1'b0;
      pressCmd(2);
      checkOutput("saveL_250", 32'(cal_low), 32'd250);

      applyStimulus(12'h800);
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_busy", 32'(busy), 32'd0);
      checkOutput("async_pct", 32'(level_pct), 32'd0);
      checkOutput("async_valid", 32'(pct_valid), 32'd0);
      checkOutput("async_calLow", 32'(cal_low), 32'd0);
      checkOutput("async_calHigh", 32'(cal_high), 32'hFFF);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
